// File: rtl/alu_core.sv
// Registered single-cycle signed ALU: out <= f(cmd, accumulator, opperand) on enabled edges.
// Optional ALU_FLAGS_EN adds a registered {Z,N,C,V} flags output.
module alu_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [3:0]            cmd,
  input  logic [DATA_WIDTH-1:0] accumulator,
  input  logic [DATA_WIDTH-1:0] opperand,
`ifdef ALU_FLAGS_EN
  output logic [3:0]            flags,
`endif
  output logic [DATA_WIDTH-1:0] out
);

  typedef enum logic [3:0] {
    CMD_PASS = 4'h0,
    CMD_ADD  = 4'h1,
    CMD_SUB  = 4'h2,
    CMD_MUL  = 4'h3,
    CMD_DIV  = 4'h4,
    CMD_MOD  = 4'h5,
    CMD_SHL  = 4'h6,
    CMD_SHR  = 4'h7,
    CMD_NEG  = 4'h8,
    CMD_AND  = 4'h9,
    CMD_OR   = 4'hA,
    CMD_XOR  = 4'hB,
    CMD_NOT  = 4'hC,
    CMD_LOAD = 4'hD
  } cmd_e;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

  logic signed [DATA_WIDTH-1:0] sa;
  logic signed [DATA_WIDTH-1:0] sb;
  logic [DATA_WIDTH-1:0]        result;
  logic                         cmd_ok;
  logic                         div_zero;
  logic                         div_ovf;

  assign sa       = accumulator;
  assign sb       = opperand;
  assign div_zero = (opperand == '0);
  // most-negative / -1 is the single quotient that cannot be represented
  assign div_ovf  = (accumulator == MOST_NEG) && (opperand == ALL_ONES);

  always_comb begin
    result = '0;
    cmd_ok = 1'b1;
    case (cmd)
      CMD_PASS: result = accumulator;
      CMD_ADD:  result = accumulator + opperand;
      CMD_SUB:  result = accumulator - opperand;
      CMD_MUL:  result = sa * sb;
      CMD_DIV: begin
        if (div_zero)     result = ALL_ONES;
        else if (div_ovf) result = MOST_NEG;
        else              result = sa / sb;
      end
      CMD_MOD: begin
        if (div_zero)     result = accumulator;
        else if (div_ovf) result = '0;
        else              result = sa % sb;
      end
      CMD_SHL:  result = accumulator << opperand[3:0];
      CMD_SHR:  result = sa >>> opperand[3:0];
      CMD_NEG:  result = -accumulator;
      CMD_AND:  result = accumulator & opperand;
      CMD_OR:   result = accumulator | opperand;
      CMD_XOR:  result = accumulator ^ opperand;
      CMD_NOT:  result = ~accumulator;
      CMD_LOAD: result = opperand;
      default:  cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) out <= '0;
    else if (enable && cmd_ok) out <= result;
  end

`ifdef ALU_FLAGS_EN
  logic [DATA_WIDTH:0]            add_ext;
  logic [DATA_WIDTH:0]            sub_ext;
  logic signed [2*DATA_WIDTH-1:0] mul_full;
  logic                           flag_c;
  logic                           flag_v;

  assign add_ext  = {1'b0, accumulator} + {1'b0, opperand};
  assign sub_ext  = {1'b0, accumulator} - {1'b0, opperand};
  assign mul_full = (2*DATA_WIDTH)'(sa) * (2*DATA_WIDTH)'(sb);

  always_comb begin
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (cmd)
      CMD_ADD: begin
        flag_c = add_ext[DATA_WIDTH];
        flag_v = (sa[DATA_WIDTH-1] == sb[DATA_WIDTH-1]) &&
                 (result[DATA_WIDTH-1] != sa[DATA_WIDTH-1]);
      end
      CMD_SUB: begin
        flag_c = sub_ext[DATA_WIDTH];
        flag_v = (sa[DATA_WIDTH-1] != sb[DATA_WIDTH-1]) &&
                 (result[DATA_WIDTH-1] != sa[DATA_WIDTH-1]);
      end
      // product fits only if the upper half is a pure sign extension of the lower
      CMD_MUL: flag_v = !((&mul_full[2*DATA_WIDTH-1:DATA_WIDTH-1]) ||
                          (~|mul_full[2*DATA_WIDTH-1:DATA_WIDTH-1]));
      CMD_DIV: flag_v = div_zero || div_ovf;
      CMD_MOD: flag_v = div_zero;
      CMD_NEG: flag_v = (accumulator == MOST_NEG);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) flags <= '0;
    else if (enable && cmd_ok)
      flags <= {(result == '0), result[DATA_WIDTH-1], flag_c, flag_v};
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vector table, hold/reset sequences, and random
// stimulus against an integer-arithmetic reference model.
module tb_alu_core;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [3:0]   cmd;
  logic [W-1:0] accumulator;
  logic [W-1:0] opperand;
  logic [W-1:0] out;
`ifdef ALU_FLAGS_EN
  logic [3:0]   flags;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   expf_q[$];

  alu_core #(.DATA_WIDTH(W)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .cmd(cmd),
    .accumulator(accumulator),
    .opperand(opperand),
`ifdef ALU_FLAGS_EN
    .flags(flags),
`endif
    .out(out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [3:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h want 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic en, input logic [3:0] c,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    reset_n = rn; enable = en; cmd = c; accumulator = a; opperand = b;
    @(posedge clock);
    #1;
  endtask

  // Reference: plain signed integer arithmetic, truncated to W bits.
  function automatic void ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic [3:0] f);
    longint sa, sb, ua, ub, t;
    logic cf, vf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    t = 0; cf = 1'b0; vf = 1'b0; r = '0;
    case (c)
      4'h0: r = a;
      4'h1: begin t = sa + sb; r = t[W-1:0]; cf = (ua + ub) > 65535; vf = (t > 32767) || (t < -32768); end
      4'h2: begin t = sa - sb; r = t[W-1:0]; cf = ua < ub; vf = (t > 32767) || (t < -32768); end
      4'h3: begin t = sa * sb; r = t[W-1:0]; vf = (t > 32767) || (t < -32768); end
      4'h4: begin
        if (sb == 0) begin r = 16'hFFFF; vf = 1'b1; end
        else begin t = sa / sb; r = t[W-1:0]; vf = t > 32767; end
      end
      4'h5: begin
        if (sb == 0) begin r = a; vf = 1'b1; end
        else begin t = sa % sb; r = t[W-1:0]; end
      end
      4'h6: begin t = ua << b[3:0]; r = t[W-1:0]; end
      4'h7: begin t = sa >>> b[3:0]; r = t[W-1:0]; end
      4'h8: begin t = -sa; r = t[W-1:0]; vf = t > 32767; end
      4'h9: r = a & b;
      4'hA: r = a | b;
      4'hB: r = a ^ b;
      4'hC: r = ~a;
      4'hD: r = b;
      default: r = '0;
    endcase
    f = {(r == 0), r[W-1], cf, vf};
  endfunction

  vec_t vecs[$];

  initial begin
    logic [W-1:0] hold_v;
    logic [W-1:0] exp_out;
    logic [3:0]   exp_flags;
    logic [W-1:0] r;
    logic [3:0]   f;

    reset_n = 1'b0; enable = 1'b0; cmd = 4'h0; accumulator = '0; opperand = '0;

    vecs.push_back('{"add_chain",  4'h1, 16'd50,   16'd32,   16'd82});
    vecs.push_back('{"sub_chain",  4'h2, 16'd82,   16'd5,    16'd77});
    vecs.push_back('{"mul_chain",  4'h3, 16'd77,   16'd9,    16'h02B5});
    vecs.push_back('{"and_chain",  4'h9, 16'h02B5, 16'h003C, 16'h0034});
    vecs.push_back('{"xor_chain",  4'hB, 16'h0034, 16'h00CA, 16'h00FE});
    vecs.push_back('{"not_chain",  4'hC, 16'h00FE, 16'h5A5A, 16'hFF01});
    vecs.push_back('{"div_neg",    4'h4, 16'hFFF9, 16'd2,    16'hFFFD});
    vecs.push_back('{"mod_neg",    4'h5, 16'hFFF9, 16'd2,    16'hFFFF});
    vecs.push_back('{"div_zero",   4'h4, 16'd100,  16'd0,    16'hFFFF});
    vecs.push_back('{"mod_zero",   4'h5, 16'd100,  16'd0,    16'd100});
    vecs.push_back('{"div_ovf",    4'h4, 16'h8000, 16'hFFFF, 16'h8000});
    vecs.push_back('{"add_wrap",   4'h1, 16'h7FFF, 16'd1,    16'h8000});
    vecs.push_back('{"shr_arith",  4'h7, 16'h8000, 16'd4,    16'hF800});
    vecs.push_back('{"shl_low4",   4'h6, 16'd1,    16'h0013, 16'h0008});
    vecs.push_back('{"pass",       4'h0, 16'h1357, 16'hFFFF, 16'h1357});
    vecs.push_back('{"load",       4'hD, 16'hAAAA, 16'h2468, 16'h2468});
    vecs.push_back('{"neg",        4'h8, 16'd5,    16'd0,    16'hFFFB});
    vecs.push_back('{"or",         4'hA, 16'h00F0, 16'h000F, 16'h00FF});

    // reset and hold
    repeat (2) drive(1'b0, 1'b1, 4'h1, 16'h1111, 16'h2222);
    chk("reset_initial", out, 16'h0000);
    drive(1'b1, 1'b1, 4'hD, 16'h0000, 16'h1234);
    chk("load_before_reset", out, 16'h1234);
    drive(1'b0, 1'b1, 4'h1, 16'h0005, 16'h0006);
    chk("reset_over_enable", out, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'(i + 1), 16'($urandom), 16'($urandom));
      chk("hold_after_reset", out, 16'h0000);
    end

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, 1'b1, vecs[i].cmd, vecs[i].a, vecs[i].b);
      chk(vecs[i].name, out, vecs[i].exp);
    end

`ifdef ALU_FLAGS_EN
    drive(1'b1, 1'b1, 4'h1, 16'h7FFF, 16'h0001);
    total++;
    if (flags !== 4'b0101) begin
      bad++;
      $display("FAIL flags_add_wrap: got %b want 0101", flags);
    end
`endif

    // enable low and reserved commands hold the last value
    drive(1'b1, 1'b1, 4'hD, 16'h0000, 16'h4321);
    hold_v = out;
    chk("load_before_hold", hold_v, 16'h4321);
    drive(1'b1, 1'b0, 4'h1, 16'h0F0F, 16'h0101);
    chk("enable_low_hold", out, 16'h4321);
    drive(1'b1, 1'b1, 4'hE, 16'h0F0F, 16'h0101);
    chk("reserved_e_hold", out, 16'h4321);
    drive(1'b1, 1'b1, 4'hF, 16'h7777, 16'h0002);
    chk("reserved_f_hold", out, 16'h4321);

    // randomized against the reference model
    exp_out = 16'h4321;
    exp_flags = 4'b0000;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    exp_out = '0;
    for (int i = 0; i < 500; i++) begin
      logic rn, en;
      logic [3:0] c;
      logic [W-1:0] a, b;
      rn = ($urandom_range(0, 19) != 0);
      en = ($urandom_range(0, 4) != 0);
      c  = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin a = 16'h8000; b = 16'hFFFF; end
      if (!rn) begin
        exp_out = '0; exp_flags = '0;
      end else if (en && c <= 4'hD) begin
        ref_alu(c, a, b, r, f);
        exp_out = r; exp_flags = f;
      end
      exp_q.push_back(exp_out);
      expf_q.push_back(exp_flags);
      drive(rn, en, c, a, b);
      chk($sformatf("rand_out_cmd%0h", c), out, exp_q.pop_front());
`ifdef ALU_FLAGS_EN
      total++;
      if (flags !== expf_q[0]) begin
        bad++;
        $display("FAIL rand_flags_cmd%0h: got %b want %b", c, flags, expf_q[0]);
      end
`endif
      void'(expf_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
